// File: rtl/jt12_i2s_pkg.sv
// Shared types and helpers for the jt12 stereo I2S output stage.
package jt12_i2s_pkg;

    localparam int FRAME_BITS = 32;
    localparam int SLOT_BITS  = 16;

    typedef struct packed {
        logic [SLOT_BITS-1:0] l;
        logic [SLOT_BITS-1:0] r;
    } stereo_t;

    // MSB-align a width-bit sample (held in the low bits of x) into a 16-bit slot.
    function automatic logic [SLOT_BITS-1:0] expand16(input logic [SLOT_BITS-1:0] x,
                                                      input int width);
        return x << (SLOT_BITS - width);
    endfunction

endpackage

// File: rtl/jt12_i2s_fifo.sv
// Two-entry FIFO for stereo words; a pop is applied before a push in the same cycle.
import jt12_i2s_pkg::*;

module jt12_i2s_fifo (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  stereo_t din,
    output stereo_t dout,
    output logic    full,
    output logic    empty
);

    stereo_t    mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_pop;
    logic       do_push;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            if (do_push)
                wr_ptr <= ~wr_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/jt12_i2s_out.sv
// Stereo I2S serializer fed from the jt12 accumulator through a 2-entry FIFO.
// Define JT12_I2S_LJ_EN for left-justified output; default is Philips I2S.
import jt12_i2s_pkg::*;

module jt12_i2s_out #(
    parameter int WIDTH    = 12,
    parameter int BCLK_DIV = 4
) (
    input  logic                    rst,
    input  logic                    clk,
    input  logic                    clk_en,
    input  logic                    sample,
    input  logic signed [WIDTH-1:0] left,
    input  logic signed [WIDTH-1:0] right,
    output logic                    i2s_bclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_data,
    output logic                    overrun,
    output logic                    underrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DIV_W-1:0]      div_cnt;
    logic [4:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shift_q;
    stereo_t               last_q;
    stereo_t               fifo_din;
    stereo_t               fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  div_wrap;
    logic                  bclk_fall;
    logic                  frame_load;

    assign push       = clk_en && sample;
    assign fifo_din   = {expand16(16'(left), WIDTH), expand16(16'(right), WIDTH)};
    assign div_wrap   = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign bclk_fall  = div_wrap && i2s_bclk;
    assign frame_load = bclk_fall && (bit_cnt == 5'd31);
    assign i2s_lrclk  = bit_cnt[4];

    jt12_i2s_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (frame_load),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
            bit_cnt  <= 5'd0;
            shift_q  <= '0;
            last_q   <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            // The frame pop frees a slot first, so a full FIFO only drops when no pop coincides.
            overrun  <= push && fifo_full && !frame_load;
            underrun <= frame_load && fifo_empty;
            div_cnt  <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            if (div_wrap)
                i2s_bclk <= ~i2s_bclk;
            if (bclk_fall) begin
                bit_cnt <= bit_cnt + 5'd1;
                if (frame_load) begin
                    if (!fifo_empty) begin
                        shift_q <= fifo_dout;
                        last_q  <= fifo_dout;
                    end else begin
                        shift_q <= last_q;
                    end
                end else begin
                    shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

`ifdef JT12_I2S_LJ_EN
    assign i2s_data = shift_q[FRAME_BITS-1];
`else
    // Philips framing: data trails the word-select edge by one bit clock.
    logic sdata_p1;

    always_ff @(posedge clk) begin
        if (rst)
            sdata_p1 <= 1'b0;
        else if (bclk_fall)
            sdata_p1 <= shift_q[FRAME_BITS-1];
    end

    assign i2s_data = sdata_p1;
`endif

endmodule
